// File: rtl/uart_tx_trama.sv
// Frame builder ahead of the UART transmitter: header, payload bytes MSB first, XOR checksum.
// Bytes are handed to the UART under a valid/ready handshake, and completed frames are counted.
module uart_tx_trama #(
   parameter int unsigned N_BYTES   = 4,
   parameter logic [7:0]  HEADER    = 8'hAA,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                   CLK100MHZ,
   input  logic                   rst_n,
   input  logic [8*N_BYTES-1:0]   palabra,
   input  logic                   enviar,
   output logic                   listo,
   output logic [7:0]             uart_dato,
   output logic                   uart_valid,
   input  logic                   uart_ready,
   output logic [CNT_WIDTH-1:0]   tramas_enviadas
);

   localparam int unsigned W    = 8 * N_BYTES;
   localparam int unsigned IDXW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HEADER,
      S_DATOS,
      S_CHECKSUM
   } state_t;

   state_t                state_q;
   logic [W-1:0]          shift_q;
   logic [W-1:0]          shift_d;
   logic [7:0]            csum_q;
   logic [7:0]            csum_d;
   logic [IDXW-1:0]       idx_q;
   logic [7:0]            dato_q;
   logic                  valid_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  xfer;

   assign xfer    = valid_q && uart_ready;
   assign shift_d = shift_q << 8;
   assign csum_d  = csum_q ^ shift_q[W-1 -: 8];

   // dato_q is loaded one transfer ahead so the byte on the wire is always a register output
   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         csum_q  <= '0;
         idx_q   <= '0;
         dato_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enviar) begin
                  shift_q <= palabra;
                  csum_q  <= '0;
                  idx_q   <= '0;
                  dato_q  <= HEADER;
                  valid_q <= 1'b1;
                  state_q <= S_HEADER;
               end
            end
            S_HEADER: begin
               if (xfer) begin
                  dato_q  <= shift_q[W-1 -: 8];
                  state_q <= S_DATOS;
               end
            end
            S_DATOS: begin
               if (xfer) begin
                  csum_q  <= csum_d;
                  shift_q <= shift_d;
                  idx_q   <= idx_q + IDXW'(1);
                  if (idx_q == IDX_LAST) begin
                     dato_q  <= csum_d;
                     state_q <= S_CHECKSUM;
                  end else begin
                     dato_q  <= shift_d[W-1 -: 8];
                  end
               end
            end
            S_CHECKSUM: begin
               if (xfer) begin
                  dato_q  <= '0;
                  valid_q <= 1'b0;
                  cnt_q   <= cnt_q + CNT_WIDTH'(1);
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign listo           = (state_q == S_IDLE);
   assign uart_dato       = dato_q;
   assign uart_valid      = valid_q;
   assign tramas_enviadas = cnt_q;

endmodule

// File: tb/tb_uart_tx_trama.sv
// Directed bench for uart_tx_trama: reset, unthrottled frame, backpressure, ignored request,
// mid-frame abort and counter wrap (counter narrowed to 4 bits so the wrap stays short).
module tb_uart_tx_trama;

   localparam int unsigned NB = 4;
   localparam int unsigned CW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [8*NB-1:0] palabra;
   logic            enviar;
   logic            listo;
   logic [7:0]      uart_dato;
   logic            uart_valid;
   logic            uart_ready;
   logic [CW-1:0]   tramas_enviadas;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [7:0]  q[$];

   uart_tx_trama #(.N_BYTES(NB), .HEADER(8'hAA), .CNT_WIDTH(CW)) dut (
      .CLK100MHZ       (clk),
      .rst_n           (rst_n),
      .palabra         (palabra),
      .enviar          (enviar),
      .listo           (listo),
      .uart_dato       (uart_dato),
      .uart_valid      (uart_valid),
      .uart_ready      (uart_ready),
      .tramas_enviadas (tramas_enviadas)
   );

   always #5 clk = ~clk;

   // Inputs only change 2 ns after a rising edge, so the negedge view is what the next edge sees
   always @(negedge clk)
      if (rst_n && uart_valid && uart_ready) q.push_back(uart_dato);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   logic [7:0] e_unth [6] = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
   logic [7:0] e_bp   [6] = '{8'hAA, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
   logic [7:0] e_ab   [6] = '{8'hAA, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
   logic [7:0] e_wr   [6] = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};

   initial begin
      rst_n      = 1'b0;
      palabra    = '0;
      enviar     = 1'b0;
      uart_ready = 1'b0;
      #3;
      chk("rst_listo", 32'(listo), 32'd1);
      chk("rst_valid", 32'(uart_valid), 32'd0);
      chk("rst_dato",  32'(uart_dato), 32'h00);
      chk("rst_cnt",   32'(tramas_enviadas), 32'd0);
      repeat (3) step();
      chk("rst_hold_listo", 32'(listo), 32'd1);
      chk("rst_hold_valid", 32'(uart_valid), 32'd0);
      rst_n = 1'b1;
      step();

      // Unthrottled frame, cycle-exact
      uart_ready = 1'b1;
      palabra    = 32'h12345678;
      enviar     = 1'b1;
      step();
      enviar  = 1'b0;
      palabra = 32'hFFFFFFFF;
      for (int j = 0; j < 6; j++) begin
         mid();
         chk($sformatf("unth_byte%0d", j), 32'(uart_dato), 32'(e_unth[j]));
         chk($sformatf("unth_valid%0d", j), 32'(uart_valid), 32'd1);
         chk($sformatf("unth_listo%0d", j), 32'(listo), 32'd0);
         step();
      end
      mid();
      chk("unth_end_listo", 32'(listo), 32'd1);
      chk("unth_end_valid", 32'(uart_valid), 32'd0);
      chk("unth_cnt", 32'(tramas_enviadas), 32'd1);
      chk("unth_count", q.size(), 32'd6);
      step();

      // Backpressure: ready high 1 cycle, low 1302, with an ignored request mid-frame
      q.delete();
      uart_ready = 1'b0;
      palabra    = 32'hDEADBEEF;
      enviar     = 1'b1;
      step();
      enviar  = 1'b0;
      palabra = 32'h00000000;
      for (int cyc = 0; cyc < 6 * 1303 + 6; cyc++) begin
         uart_ready = ((cyc % 1303) == 0);
         enviar     = (cyc == 500);
         mid();
         if (uart_valid && !uart_ready && (cyc % 97 == 5))
            chk("bp_hold", 32'(uart_dato), (q.size() < 6) ? 32'(e_bp[q.size()]) : 32'hFFFF);
         step();
      end
      enviar     = 1'b0;
      uart_ready = 1'b1;
      mid();
      chk("bp_count", q.size(), 32'd6);
      for (int j = 0; j < 6; j++)
         chk($sformatf("bp_byte%0d", j), (j < q.size()) ? 32'(q[j]) : 32'hFFFF, 32'(e_bp[j]));
      chk("bp_cnt", 32'(tramas_enviadas), 32'd2);
      chk("bp_listo", 32'(listo), 32'd1);
      step();

      // Abort mid-frame after the 0x34 transfer
      q.delete();
      palabra = 32'h12345678;
      enviar  = 1'b1;
      step();
      enviar = 1'b0;
      repeat (3) step();
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(uart_valid), 32'd0);
      chk("abort_dato",  32'(uart_dato), 32'h00);
      chk("abort_listo", 32'(listo), 32'd1);
      chk("abort_cnt",   32'(tramas_enviadas), 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      q.delete();
      palabra = 32'hA5A5A5A5;
      enviar  = 1'b1;
      step();
      enviar = 1'b0;
      repeat (8) step();
      chk("abort_bytes", q.size(), 32'd6);
      for (int j = 0; j < 6; j++)
         chk($sformatf("abort_byte%0d", j), (j < q.size()) ? 32'(q[j]) : 32'hFFFF, 32'(e_ab[j]));
      chk("abort_post_cnt", 32'(tramas_enviadas), 32'd1);

      // Counter wrap with enviar held: 17 frames, 7 cycles apart
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      q.delete();
      palabra = 32'h01020304;
      enviar  = 1'b1;
      step();
      for (int c = 0; c < 119; c++) begin
         mid();
         if (c % 7 == 0) chk($sformatf("wrap_hdr%0d", c), 32'(uart_dato), 32'hAA);
         if (c % 7 == 6) begin
            chk($sformatf("wrap_listo%0d", c), 32'(listo), 32'd1);
            chk($sformatf("wrap_cnt%0d", c), 32'(tramas_enviadas), 32'((c / 7 + 1) % 16));
         end
         if (c == 112) enviar = 1'b0;
         step();
      end
      chk("wrap_final_cnt", 32'(tramas_enviadas), 32'd1);
      chk("wrap_bytes", q.size(), 32'd102);
      for (int j = 0; j < 6; j++)
         chk($sformatf("wrap_last_byte%0d", j), (96 + j < q.size()) ? 32'(q[96 + j]) : 32'hFFFF, 32'(e_wr[j]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
